div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 119 +++++++++++
 tb/tb_div_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider controller for the EX stage: stalls the pipeline
// while a DIV/MOD/DIVU/MODU runs and presents the result for one cycle.
module div_ctrl #(
   parameter int unsigned XLEN = 32
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic            ex_valid,
   input  logic [4:0]      aluctrl,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            stall,
   output logic [XLEN-1:0] result,
   output logic            result_valid
);

   localparam int unsigned CNT_W = 6;
   localparam logic [4:0] OP_DIV  = 5'd14;
   localparam logic [4:0] OP_MOD  = 5'd15;
   localparam logic [4:0] OP_DIVU = 5'd16;
   localparam logic [4:0] OP_MODU = 5'd17;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [4:0]        op_q;
   logic [XLEN-1:0]   dvd_q, dvs_q, rem_q, quo_q, result_q;
   logic              qneg_q, rneg_q, live_q;

   logic              is_div_c, signed_c, mod_in_c, launch_c, mod_c, qbit_c;
   logic              neg1_c, neg2_c;
   logic [XLEN-1:0]   abs1_c, abs2_c, rem_nx_c, quo_nx_c, qfix_c, rfix_c;
   logic [XLEN:0]     shift_c, diff_c;

   // Decode and launch qualification; live_q blocks launches in the first cycle after reset.
   assign is_div_c = (aluctrl >= OP_DIV) && (aluctrl <= OP_MODU);
   assign signed_c = (aluctrl == OP_DIV) || (aluctrl == OP_MOD);
   assign mod_in_c = (aluctrl == OP_MOD) || (aluctrl == OP_MODU);
   assign launch_c = live_q && (state_q == S_IDLE) && ex_valid && is_div_c && !flush;
   assign mod_c    = (op_q == OP_MOD) || (op_q == OP_MODU);

   assign stall        = aresetn && !flush && (launch_c || (state_q == S_CALC));
   assign result_valid = aresetn && !flush && (state_q == S_DONE);
   assign result       = result_q;

   assign neg1_c = signed_c && src1[XLEN-1];
   assign neg2_c = signed_c && src2[XLEN-1];
   assign abs1_c = neg1_c ? (~src1) + XLEN'(1) : src1;
   assign abs2_c = neg2_c ? (~src2) + XLEN'(1) : src2;

   // One restoring step; the extra bit keeps the shifted remainder exact.
   assign shift_c  = {rem_q, dvd_q[XLEN-1]};
   assign diff_c   = shift_c - {1'b0, dvs_q};
   assign qbit_c   = ~diff_c[XLEN];
   assign rem_nx_c = qbit_c ? diff_c[XLEN-1:0] : shift_c[XLEN-1:0];
   assign quo_nx_c = {quo_q[XLEN-2:0], qbit_c};
   assign qfix_c   = qneg_q ? (~quo_nx_c) + XLEN'(1) : quo_nx_c;
   assign rfix_c   = rneg_q ? (~rem_nx_c) + XLEN'(1) : rem_nx_c;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         result_q <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         live_q   <= 1'b0;
      end else begin
         live_q <= 1'b1;
         if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (launch_c) begin
                     op_q   <= aluctrl;
                     dvd_q  <= abs1_c;
                     dvs_q  <= abs2_c;
                     rem_q  <= '0;
                     quo_q  <= '0;
                     cnt_q  <= '0;
                     qneg_q <= neg1_c ^ neg2_c;
                     rneg_q <= neg1_c;
                     // Divide by zero bypasses the iterations entirely.
                     if (src2 == '0) begin
                        state_q  <= S_DONE;
                        result_q <= mod_in_c ? src1 : '1;
                     end else begin
                        state_q <= S_CALC;
                     end
                  end
               end
               S_CALC: begin
                  dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
                  rem_q <= rem_nx_c;
                  quo_q <= quo_nx_c;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) begin
                     state_q  <= S_DONE;
                     result_q <= mod_c ? rfix_c : qfix_c;
                  end
               end
               S_DONE:  state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed scoreboard bench for div_ctrl: expected results queued at launch,
// popped and compared (value and arrival cycle) whenever result_valid is seen.
module tb_div_ctrl;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        ex_valid = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  aluctrl = '0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        stall, result_valid;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [31:0] last_res = '0;

   typedef struct {
      string       name;
      logic [31:0] val;
      int          cyc;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   div_ctrl #(.XLEN(32)) dut (
      .aclk(aclk), .aresetn(aresetn), .ex_valid(ex_valid), .aluctrl(aluctrl),
      .src1(src1), .src2(src2), .flush(flush), .stall(stall),
      .result(result), .result_valid(result_valid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every result_valid pulse must match the oldest queued expectation.
   always @(negedge aclk) begin
      if (result_valid !== 1'b0) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got result_valid=%b at cycle %0d expected 0", result_valid, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk({mon_e.name, "_val"}, result, mon_e.val);
            chk({mon_e.name, "_cyc"}, 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   task automatic run_div(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input int lat);
      int  c0, sc;
      bit  seen;
      @(posedge aclk); #1;
      ex_valid = 1'b1; aluctrl = op; src1 = a; src2 = b;
      c0 = cyc;
      sb_q.push_back('{name, expv, c0 + lat});
      sc = 0; seen = 0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge aclk);
         if (stall === 1'b1) sc++;
         if (result_valid === 1'b1) seen = 1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no result_valid within 100 cycles expected pulse at cycle %0d", name, c0 + lat);
      end
      chk({name, "_stall_cycles"}, 32'(sc), 32'(lat));
      last_res = expv;
   endtask

   task automatic go_idle();
      @(posedge aclk); #1;
      ex_valid = 1'b0; aluctrl = '0; src1 = '0; src2 = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by time %0t expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a divide waiting in EX: outputs must stay quiet.
      ex_valid = 1'b1; aluctrl = 5'd16; src1 = 32'd100; src2 = 32'd7;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         chk("rst_stall", 32'(stall), 32'd0);
         chk("rst_valid", 32'(result_valid), 32'd0);
      end
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      chk("post_rst_stall", 32'(stall), 32'd0);
      chk("rst_result", result, 32'd0);
      go_idle();
      repeat (2) @(posedge aclk);

      run_div("divu_100_7", 5'd16, 32'd100, 32'd7, 32'd14, 33);
      run_div("modu_100_7", 5'd17, 32'd100, 32'd7, 32'd2, 33);
      run_div("div_m7_2",   5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_div("mod_m7_2",   5'd15, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_div("div_7_m2",   5'd14, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      run_div("mod_7_m2",   5'd15, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
      run_div("div_5_0",    5'd14, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_div("mod_5_0",    5'd15, 32'd5, 32'd0, 32'd5, 1);
      run_div("modu_dead_0", 5'd17, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1);
      run_div("div_ovf",    5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      run_div("mod_ovf",    5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
      run_div("divu_max_1", 5'd16, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
      // Back-to-back: second launch in the cycle right after DONE.
      run_div("b2b_divu_9_3", 5'd16, 32'd9, 32'd3, 32'd3, 33);
      run_div("b2b_modu_9_4", 5'd17, 32'd9, 32'd4, 32'd1, 33);
      go_idle();

      // Non-divide ops, even with a zero divisor, must not stall or touch result.
      @(posedge aclk); #1;
      ex_valid = 1'b1; aluctrl = 5'd0; src1 = 32'd77; src2 = 32'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         chk("nondiv_stall", 32'(stall), 32'd0);
         @(posedge aclk); #1;
         aluctrl = (i[0]) ? 5'd18 : 5'd13;
      end
      @(negedge aclk);
      chk("nondiv_result", result, last_res);
      go_idle();

      // Flush at cycle 10 of a DIVU.
      @(posedge aclk); #1;
      ex_valid = 1'b1; aluctrl = 5'd16; src1 = 32'd1000; src2 = 32'd3;
      repeat (10) @(posedge aclk);
      #1;
      flush = 1'b1; ex_valid = 1'b0;
      @(negedge aclk);
      chk("flush_stall", 32'(stall), 32'd0);
      chk("flush_valid", 32'(result_valid), 32'd0);
      @(posedge aclk); #1;
      flush = 1'b0;
      @(negedge aclk);
      chk("flush_idle_stall", 32'(stall), 32'd0);
      repeat (40) @(negedge aclk);
      chk("flush_result_hold", result, last_res);

      // Reset at cycle 5 of a divide.
      @(posedge aclk); #1;
      ex_valid = 1'b1; aluctrl = 5'd16; src1 = 32'd100; src2 = 32'd7;
      repeat (5) @(posedge aclk);
      #1;
      aresetn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge aclk);
         chk("midrst_stall", 32'(stall), 32'd0);
         chk("midrst_valid", 32'(result_valid), 32'd0);
         @(posedge aclk); #1;
      end
      aresetn = 1'b1;
      @(negedge aclk);
      chk("midrst_first_stall", 32'(stall), 32'd0);
      chk("midrst_result", result, 32'd0);
      go_idle();
      repeat (40) @(negedge aclk);
      chk("midrst_result_hold", result, 32'd0);

      run_div("post_rst_divu", 5'd16, 32'd100, 32'd7, 32'd14, 33);
      go_idle();
      repeat (5) @(posedge aclk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
